wb_master_burst: RTL

- Parametrised Wishbone B3 bus master; next generation of the single-transfer master interface.
- Adds:
  - incrementing bursts of 1..MAX_BURST beats, using registered-feedback cycle types
  - automatic retry on wb_rty_i
  - bus watchdog timeout
  - per-command completion status
- Sits between DSP/control engines and the shared Wishbone interconnect.

---
 rtl/wb_master_pkg.sv | 22 ++
 rtl/wb_master_watchdog.sv | 43 ++++
 rtl/wb_master_burst.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared constants and encodings for the Wishbone burst master.
package wb_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BUSERR   = 2'b01;
  localparam logic [1:0] ST_RETRY    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUS       = 2'd1,
    S_RETRY_GAP = 2'd2,
    S_FINISH    = 2'd3
  } state_e;

endpackage

// File: rtl/wb_master_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT. TIMEOUT=0 removes the counter.
module wb_master_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_w;
      assign unused_w  = ^{clk_i, rst_i, clr_i, en_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // next count: clear wins, otherwise count while enabled, saturating
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // count register
      always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      // fires in the cycle whose count step lands on TIMEOUT
      assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_master_burst.sv
// Wishbone B3 bus master with incrementing bursts, retry and watchdog.
//
// state       | meaning
// S_IDLE      | waiting for start; command fields latched on start
// S_BUS       | cyc/stb asserted, waiting for ack/err/rty
// S_RETRY_GAP | one cycle with cyc/stb low after rty, then re-issue
// S_FINISH    | done pulse, status and beats_done valid
module wb_master_burst
  import wb_master_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  output logic [AW-1:0]                wb_adr_o,
  output logic [DW-1:0]                wb_dat_o,
  output logic [DW/8-1:0]              wb_sel_o,
  output logic                         wb_we_o,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic [2:0]                   wb_cti_o,
  output logic [1:0]                   wb_bte_o,
  input  logic [DW-1:0]                wb_dat_i,
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i,
  input  logic                         wb_rty_i,
  input  logic                         start,
  input  logic [AW-1:0]                address,
  input  logic [DW/8-1:0]              selection,
  input  logic                         write,
  input  logic [$clog2(MAX_BURST):0]   length,
  input  logic [DW-1:0]                wr_data,
  output logic                         wr_next,
  output logic [DW-1:0]                rd_data,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   status,
  output logic [$clog2(MAX_BURST):0]   beats_done
);

  localparam int LW  = $clog2(MAX_BURST) + 1;
  localparam int RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int BPB = DW / 8;

  state_e          state_q, state_d;
  logic [AW-1:0]   adr_q;
  logic [DW/8-1:0] sel_q;
  logic            we_q;
  logic            cyc_q;
  logic [2:0]      cti_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   beats_q;
  logic [RW-1:0]   retry_q;
  logic [1:0]      status_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;

  logic            in_bus, accept;
  logic            ev_err, ev_rty, ev_ack, ev_to;
  logic            last_beat, retry_max;
  logic            wd_clr, wd_expired;
  logic [LW-1:0]   len_eff;

  // bus events, resolved with err > rty > ack > watchdog priority
  always_comb begin
    in_bus    = (state_q == S_BUS);
    accept    = (state_q == S_IDLE) && start;
    ev_err    = in_bus && wb_err_i;
    ev_rty    = in_bus && !wb_err_i && wb_rty_i;
    ev_ack    = in_bus && !wb_err_i && !wb_rty_i && wb_ack_i;
    ev_to     = in_bus && !wb_err_i && !wb_rty_i && !wb_ack_i && wd_expired;
    last_beat = ((beats_q + LW'(1)) == len_q);
    retry_max = (retry_q == RW'(MAX_RETRY));
    wd_clr    = accept || ev_rty || ev_ack;
    len_eff   = (length == '0) ? LW'(1) : length;
  end

  wb_master_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_i     (wb_clk),
    .rst_i     (wb_rst),
    .clr_i     (wd_clr),
    .en_i      (in_bus),
    .expired_o (wd_expired)
  );

  // state register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_BUS;
      S_BUS: begin
        if (ev_err)                   state_d = S_FINISH;
        else if (ev_rty)              state_d = retry_max ? S_FINISH : S_RETRY_GAP;
        else if (ev_ack && last_beat) state_d = S_FINISH;
        else if (ev_to)               state_d = S_FINISH;
      end
      S_RETRY_GAP: state_d = S_BUS;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // command datapath: address/cti stepping, counters, status and read capture
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
      len_q      <= '0;
      beats_q    <= '0;
      retry_q    <= '0;
      status_q   <= ST_OK;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cyc_q      <= (state_d == S_BUS);
      rd_valid_q <= 1'b0;
      if (accept) begin
        adr_q   <= address;
        sel_q   <= selection;
        we_q    <= write;
        len_q   <= len_eff;
        beats_q <= '0;
        retry_q <= '0;
        cti_q   <= (len_eff == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
      end
      if (ev_err) status_q <= ST_BUSERR;
      if (ev_rty) begin
        if (retry_max) status_q <= ST_RETRY;
        else           retry_q  <= retry_q + RW'(1);
      end
      if (ev_ack) begin
        beats_q <= beats_q + LW'(1);
        adr_q   <= adr_q + AW'(BPB);
        if (!we_q) begin
          rd_data_q  <= wb_dat_i;
          rd_valid_q <= 1'b1;
        end
        if (last_beat) status_q <= ST_OK;
        else           cti_q    <= ((beats_q + LW'(2)) == len_q) ? CTI_EOB : CTI_INCR;
      end
      if (ev_to) status_q <= ST_TIMEOUT;
    end
  end

  // outputs decoded from state and the current bus response
  always_comb begin
    busy     = (state_q == S_BUS) || (state_q == S_RETRY_GAP);
    done     = (state_q == S_FINISH);
    wr_next  = ev_ack && we_q;
    wb_dat_o = (in_bus && we_q) ? wr_data : '0;
  end

  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_cti_o   = cti_q;
  assign wb_bte_o   = BTE_LINEAR;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign status     = status_q;
  assign beats_done = beats_q;

endmodule
